// File: rtl/ps2_rx_ctrl.sv
// ps2_rx_ctrl
// -----------------------------------------------------------------------------
// PS/2 device-to-host receive controller. Takes the debounced PS/2 clock and
// data lines (both already synchronous to clk and equally delayed), frames the
// 11-bit packet (start, 8 data LSB first, odd parity, stop), checks parity and
// the stop bit, and offers each good byte on a valid/ready port.
//
// Optional feature macro: PS2_RX_TIMEOUT_EN
//   defined   : a watchdog aborts a frame after TIMEOUT clk cycles without a
//               PS/2 clock falling edge and pulses o_timeout_err.
//   undefined : no watchdog, o_timeout_err is always 0, TIMEOUT is ignored.
//
// Ports
//   clk           in   system clock
//   rst_n         in   asynchronous active-low reset
//   i_ps2_clk     in   debounced PS/2 clock
//   i_ps2_data    in   debounced PS/2 data
//   o_rx_data     out  received byte, stable while o_rx_valid=1
//   o_rx_valid    out  o_rx_data holds an unconsumed byte
//   i_rx_ready    in   consumer accepts o_rx_data this cycle
//   o_parity_err  out  1-cycle pulse, parity wrong, byte dropped
//   o_frame_err   out  1-cycle pulse, stop bit was 0, byte dropped
//   o_overrun_err out  1-cycle pulse, good byte dropped (holding reg full)
//   o_timeout_err out  1-cycle pulse, frame aborted by watchdog
//   o_busy        out  receiver is inside a frame
//   o_state       out  debug view of the FSM state (0 IDLE,1 DATA,2 PARITY,3 STOP)
//
// Handshake: a transfer happens on every cycle where o_rx_valid & i_rx_ready
// are both 1. o_rx_valid drops the following cycle unless a new byte is loaded
// in that same cycle, in which case it stays 1 with the new data. i_rx_ready
// while o_rx_valid=0 is ignored; o_rx_data never changes while a byte waits.
// -----------------------------------------------------------------------------
module ps2_rx_ctrl #(
  parameter int TIMEOUT = 12500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  input  logic       i_rx_ready,
  output logic       o_parity_err,
  output logic       o_frame_err,
  output logic       o_overrun_err,
  output logic       o_timeout_err,
  output logic       o_busy,
  output logic [1:0] o_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t     r_state;
  logic       r_clk_prev;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_shift;
  logic       r_par_acc;
  logic       r_par_bit;
  logic [7:0] r_rx_data;
  logic       r_rx_valid;
  logic       r_parity_err;
  logic       r_frame_err;
  logic       r_overrun_err;
  logic       r_timeout_err;
  logic       r_busy;

  logic       w_fall;
  logic       w_timeout;

  // Reset value 0 of r_clk_prev means the debouncer's low-after-reset output
  // can never look like a falling edge; the line has to go high first.
  assign w_fall = r_clk_prev & ~i_ps2_clk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_clk_prev <= 1'b0;
    else        r_clk_prev <= i_ps2_clk;
  end

`ifdef PS2_RX_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] r_wd_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wd_cnt <= '0;
    end else if (r_state == IDLE || w_fall) begin
      r_wd_cnt <= '0;
    end else if (r_wd_cnt != WD_W'(TIMEOUT)) begin
      r_wd_cnt <= r_wd_cnt + WD_W'(1);
    end
  end

  // A fall in the same cycle counts as activity, so it wins over the abort;
  // this also keeps timeout_err exclusive with the stop-bit error pulses.
  assign w_timeout = (r_state != IDLE) && !w_fall && (r_wd_cnt == WD_W'(TIMEOUT));
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT != 0);
  assign w_timeout        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_bit_cnt     <= 3'd0;
      r_shift       <= 8'h00;
      r_par_acc     <= 1'b0;
      r_par_bit     <= 1'b0;
      r_rx_data     <= 8'h00;
      r_rx_valid    <= 1'b0;
      r_parity_err  <= 1'b0;
      r_frame_err   <= 1'b0;
      r_overrun_err <= 1'b0;
      r_timeout_err <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_parity_err  <= 1'b0;
      r_frame_err   <= 1'b0;
      r_overrun_err <= 1'b0;
      r_timeout_err <= 1'b0;

      // Consumer takes the byte; a load below in this same cycle overrides.
      if (r_rx_valid && i_rx_ready) r_rx_valid <= 1'b0;

      if (w_timeout) begin
        r_state       <= IDLE;
        r_busy        <= 1'b0;
        r_timeout_err <= 1'b1;
      end else if (w_fall) begin
        case (r_state)
          IDLE: begin
            // A high data line at a fall is not a start bit; ignore it.
            if (!i_ps2_data) begin
              r_state   <= DATA;
              r_busy    <= 1'b1;
              r_bit_cnt <= 3'd0;
              r_par_acc <= 1'b0;
            end
          end
          DATA: begin
            r_shift   <= {i_ps2_data, r_shift[7:1]};
            r_par_acc <= r_par_acc ^ i_ps2_data;
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) r_state <= PARITY;
          end
          PARITY: begin
            r_par_bit <= i_ps2_data;
            r_state   <= STOP;
          end
          STOP: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            if (!i_ps2_data) begin
              r_frame_err <= 1'b1;
            end else if ((r_par_acc ^ r_par_bit) != 1'b1) begin
              r_parity_err <= 1'b1;
            end else if (!r_rx_valid || i_rx_ready) begin
              r_rx_data  <= r_shift;
              r_rx_valid <= 1'b1;
            end else begin
              r_overrun_err <= 1'b1;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign o_rx_data     = r_rx_data;
  assign o_rx_valid    = r_rx_valid;
  assign o_parity_err  = r_parity_err;
  assign o_frame_err   = r_frame_err;
  assign o_overrun_err = r_overrun_err;
  assign o_timeout_err = r_timeout_err;
  assign o_busy        = r_busy;
  assign o_state       = r_state;

endmodule

// File: tb/tb_ps2_rx_ctrl.sv
// Testbench for ps2_rx_ctrl: directed PS/2 frames, scoreboard queues for
// delivered bytes and error pulses, monitor on the falling clk edge.
module tb_ps2_rx_ctrl;

  localparam int TIMEOUT = 100;

  localparam logic [2:0] E_PAR = 3'd1;
  localparam logic [2:0] E_FRM = 3'd2;
  localparam logic [2:0] E_OVR = 3'd3;
  localparam logic [2:0] E_TMO = 3'd4;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b0;
  logic       ps2_data = 1'b0;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       parity_err;
  logic       frame_err;
  logic       overrun_err;
  logic       timeout_err;
  logic       busy;
  logic [1:0] state;

  always #5 clk = ~clk;

  ps2_rx_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_ps2_clk    (ps2_clk),
    .i_ps2_data   (ps2_data),
    .o_rx_data    (rx_data),
    .o_rx_valid   (rx_valid),
    .i_rx_ready   (rx_ready),
    .o_parity_err (parity_err),
    .o_frame_err  (frame_err),
    .o_overrun_err(overrun_err),
    .o_timeout_err(timeout_err),
    .o_busy       (busy),
    .o_state      (state)
  );

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  logic [2:0] err_q[$];
  int checks = 0;
  int errors = 0;
  int valid_cycles = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a transfer or pulse.
  always @(negedge clk) begin
    int n;
    logic [2:0] kind;
    if (rst_n) begin
      n = int'(parity_err) + int'(frame_err) + int'(overrun_err) + int'(timeout_err);
      kind = parity_err ? E_PAR : frame_err ? E_FRM : overrun_err ? E_OVR : E_TMO;
      if (n > 1) check("err_exclusive", n, 1);
      if (n == 1) begin
        if (err_q.size() == 0) check("err_unexpected", kind, 0);
        else check("err_kind", kind, err_q.pop_front());
      end
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL xfer_unexpected: got 0x%0h expected none", rx_data);
        end else begin
          check("xfer_data", rx_data, exp_q.pop_front());
        end
      end
      if (rx_valid) valid_cycles++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One PS/2 bit: clock high with data set up, then clock low (the fall).
  // ready_on_fall raises rx_ready for exactly the fall/evaluate cycle.
  task automatic send_bit(input logic b, input logic ready_on_fall);
    @(posedge clk); #1;
    ps2_data = b;
    ps2_clk  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    ps2_clk = 1'b0;
    if (ready_on_fall) rx_ready = 1'b1;
    @(posedge clk); #1;
    if (ready_on_fall) rx_ready = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic line_idle();
    @(posedge clk); #1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_flip,
                            input logic stop, input logic ready_on_stop);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i], 1'b0);
    send_bit((~^d) ^ par_flip, 1'b0);
    send_bit(stop, ready_on_stop);
    line_idle();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [7:0] d;

    // Reset held with lines low.
    wait_cycles(3);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_err_pulses", {parity_err, frame_err, overrun_err, timeout_err}, 4'b0000);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    wait_cycles(5);
    check("post_rst_state", state, 0);
    check("post_rst_busy", busy, 0);

    // Good frame 0x1C with consumer ready.
    rx_ready = 1'b1;
    exp_q.push_back(8'h1C);
    valid_cycles = 0;
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    wait_cycles(5);
    check("good_valid_cycles", valid_cycles, 1);
    check("good_busy_after", busy, 0);
    check("good_rx_valid_after", rx_valid, 0);

    // Wrong parity, then stop bit 0 with correct parity.
    err_q.push_back(E_PAR);
    valid_cycles = 0;
    send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
    wait_cycles(5);
    check("par_valid_cycles", valid_cycles, 0);
    check("par_data_kept", rx_data, 8'h1C);
    err_q.push_back(E_FRM);
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
    wait_cycles(5);
    check("frm_valid_cycles", valid_cycles, 0);

    // Backpressure: second byte overruns, first held until one ready pulse.
    rx_ready = 1'b0;
    exp_q.push_back(8'hF0);
    send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
    err_q.push_back(E_OVR);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    wait_cycles(3);
    check("bp_valid_held", rx_valid, 1);
    check("bp_data_held", rx_data, 8'hF0);
    rx_ready = 1'b1;
    wait_cycles(1);
    rx_ready = 1'b0;
    wait_cycles(2);
    check("bp_valid_drained", rx_valid, 0);

    // Back-to-back: ready only on the second stop-bit evaluate cycle.
    exp_q.push_back(8'hF0);
    send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
    exp_q.push_back(8'h1C);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b1);
    wait_cycles(3);
    check("b2b_valid_stays", rx_valid, 1);
    check("b2b_new_data", rx_data, 8'h1C);
    rx_ready = 1'b1;
    wait_cycles(1);
    rx_ready = 1'b0;
    wait_cycles(2);
    check("b2b_valid_drained", rx_valid, 0);

    // Stalled frame: start + 4 data bits of 0x5A, then no clock activity.
    rx_ready = 1'b1;
    d = 8'h5A;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i], 1'b0);
    line_idle();
`ifdef PS2_RX_TIMEOUT_EN
    err_q.push_back(E_TMO);
    wait_cycles(120);
    check("tmo_busy", busy, 0);
    check("tmo_state", state, 0);
    exp_q.push_back(8'h5A);
    valid_cycles = 0;
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
    wait_cycles(5);
    check("tmo_next_frame_valid", valid_cycles, 1);
`else
    wait_cycles(150);
    check("stall_busy", busy, 1);
    check("stall_state", state, 1);
    exp_q.push_back(8'h5A);
    valid_cycles = 0;
    for (int i = 4; i < 8; i++) send_bit(d[i], 1'b0);
    send_bit(~^d, 1'b0);
    send_bit(1'b1, 1'b0);
    line_idle();
    wait_cycles(5);
    check("stall_resume_valid", valid_cycles, 1);
`endif

    // Reset mid-frame with a byte pending: everything back to reset values.
    rx_ready = 1'b0;
    send_frame(8'h33, 1'b0, 1'b1, 1'b0);
    wait_cycles(2);
    check("mid_pending_data", rx_data, 8'h33);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    wait_cycles(1);
    check("mid_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", rx_valid, 0);
    check("mid_rst_data", rx_data, 8'h00);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_state", state, 0);
    wait_cycles(2);
    rst_n = 1'b1;
    wait_cycles(3);

    check("exp_q_empty", exp_q.size(), 0);
    check("err_q_empty", err_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
